// File: rtl/ltc2195_spi_responder.sv
// LTC2195 serial-port responder: decodes 16-bit SPI words in the clk_in domain
// and holds the A1-A4 configuration registers, with readback on spi_sdo_out.
module ltc2195_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  A1_DEFAULT  = 8'h00,
  parameter logic [7:0]  A2_DEFAULT  = 8'h00,
  parameter logic [7:0]  A3_DEFAULT  = 8'h00,
  parameter logic [7:0]  A4_DEFAULT  = 8'h00
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       spi_scs_in,
  input  logic       spi_sck_in,
  input  logic       spi_sdi_in,
  output logic       spi_sdo_out,
  output logic [7:0] cfg_a1_out,
  output logic [7:0] cfg_a2_out,
  output logic [7:0] cfg_a3_out,
  output logic [7:0] cfg_a4_out,
  output logic       wr_stb_out,
  output logic [6:0] wr_addr_out,
  output logic       soft_rst_out,
  output logic       xfer_err_out
);

  typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} state_e;

  localparam logic [3:0][7:0] CfgDefault = {A4_DEFAULT, A3_DEFAULT, A2_DEFAULT, A1_DEFAULT};

  logic [SYNC_STAGES-1:0] scs_sync_q, scs_sync_d, sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic       scs_prev_q, scs_prev_d, sck_prev_q, sck_prev_d;
  state_e     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic [4:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] rd_q, rd_d;
  logic       sdo_q, sdo_d;
  logic       commit_q, commit_d;
  logic [7:0] cdata_q, cdata_d;
  logic [3:0][7:0] cfg_q, cfg_d;
  logic       wr_stb_q, wr_stb_d, soft_rst_q, soft_rst_d, xfer_err_q, xfer_err_d;
  logic [6:0] wr_addr_q, wr_addr_d;

  logic       scs_s, sck_s, sdi_s;
  logic       sck_rise, sck_fall, scs_rise, scs_fall;
  logic [7:0] byte_in, rd_sel;

  always_comb begin
    scs_sync_d = {scs_sync_q[SYNC_STAGES-2:0], spi_scs_in};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], spi_sck_in};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi_in};
    scs_s      = scs_sync_q[SYNC_STAGES-1];
    sck_s      = sck_sync_q[SYNC_STAGES-1];
    sdi_s      = sdi_sync_q[SYNC_STAGES-1];
    scs_prev_d = scs_s;
    sck_prev_d = sck_s;
    sck_rise   = sck_s & ~sck_prev_q;
    sck_fall   = ~sck_s & sck_prev_q;
    scs_rise   = scs_s & ~scs_prev_q;
    scs_fall   = ~scs_s & scs_prev_q;
  end

  // Bits land MSB first by position, so the byte is complete on the 8th/16th rise.
  always_comb begin
    byte_in = byte_q;
    byte_in[3'd7 - cnt_q[2:0]] = sdi_s;
    rd_sel = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (byte_in[6:0] == 7'(i + 1)) rd_sel = cfg_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    sdo_d      = sdo_q;
    commit_d   = 1'b0;
    cdata_d    = cdata_q;
    xfer_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        sdo_d = 1'b0;
        if (scs_fall) begin
          state_d = StCmd;
          byte_d  = 8'h00;
          cnt_d   = 5'd0;
        end
      end
      StCmd: begin
        if (scs_rise) begin
          state_d    = StIdle;
          xfer_err_d = (cnt_q != 5'd0);
        end else if (sck_rise) begin
          byte_d = byte_in;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            rw_d    = byte_in[7];
            addr_d  = byte_in[6:0];
            rd_d    = byte_in[7] ? rd_sel : 8'h00;
            state_d = StData;
          end
        end
      end
      StData: begin
        // A 16th rise coinciding with SCS rise still completes the word.
        if (sck_rise && cnt_q == 5'd15) begin
          byte_d   = byte_in;
          cnt_d    = 5'd16;
          commit_d = ~rw_q;
          cdata_d  = byte_in;
          state_d  = scs_rise ? StIdle : StDone;
        end else if (scs_rise) begin
          state_d    = StIdle;
          xfer_err_d = 1'b1;
        end else begin
          if (sck_rise) begin
            byte_d = byte_in;
            cnt_d  = cnt_q + 5'd1;
          end
          if (sck_fall) begin
            sdo_d = rd_q[7];
            rd_d  = {rd_q[6:0], 1'b0};
          end
        end
      end
      StDone: begin
        if (scs_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (scs_s) sdo_d = 1'b0;
  end

  always_comb begin
    cfg_d      = cfg_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    soft_rst_d = 1'b0;
    if (commit_q) begin
      if (addr_q == 7'd0) begin
        if (cdata_q[7]) begin
          soft_rst_d = 1'b1;
          cfg_d      = CfgDefault;
        end
      end else if (addr_q <= 7'd4) begin
        wr_stb_d  = 1'b1;
        wr_addr_d = addr_q;
        for (int i = 0; i < 4; i++) begin
          if (addr_q == 7'(i + 1)) cfg_d[i] = cdata_q;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      scs_sync_q <= '1;
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      scs_prev_q <= 1'b1;
      sck_prev_q <= 1'b0;
      state_q    <= StIdle;
      byte_q     <= 8'h00;
      cnt_q      <= 5'd0;
      rw_q       <= 1'b0;
      addr_q     <= 7'd0;
      rd_q       <= 8'h00;
      sdo_q      <= 1'b0;
      commit_q   <= 1'b0;
      cdata_q    <= 8'h00;
      cfg_q      <= CfgDefault;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= 7'd0;
      soft_rst_q <= 1'b0;
      xfer_err_q <= 1'b0;
    end else begin
      scs_sync_q <= scs_sync_d;
      sck_sync_q <= sck_sync_d;
      sdi_sync_q <= sdi_sync_d;
      scs_prev_q <= scs_prev_d;
      sck_prev_q <= sck_prev_d;
      state_q    <= state_d;
      byte_q     <= byte_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      sdo_q      <= sdo_d;
      commit_q   <= commit_d;
      cdata_q    <= cdata_d;
      cfg_q      <= cfg_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      soft_rst_q <= soft_rst_d;
      xfer_err_q <= xfer_err_d;
    end
  end

  assign spi_sdo_out  = sdo_q;
  assign cfg_a1_out   = cfg_q[0];
  assign cfg_a2_out   = cfg_q[1];
  assign cfg_a3_out   = cfg_q[2];
  assign cfg_a4_out   = cfg_q[3];
  assign wr_stb_out   = wr_stb_q;
  assign wr_addr_out  = wr_addr_q;
  assign soft_rst_out = soft_rst_q;
  assign xfer_err_out = xfer_err_q;

endmodule
